// File: rtl/hex_scan_controller.sv
// Time-multiplexed common-anode seven-segment scanner with blanking between digits
// and frame-aligned value updates through a single-entry pending buffer.

module hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Active-low segments, bit0 = a .. bit6 = g.
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module hex_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    lz_suppress,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              seg,
  output logic                    frame_done
);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int VW   = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [VW-1:0]         shadow, pending;
  logic                  pending_full;
  logic                  accept, load, boundary, frame_done_n;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [3:0]            nib_sel;
  logic [6:0]            dec_seg, seg_n;
  logic [NUM_DIGITS-1:0] sel_n;

  assign value_ready = ~pending_full;
  assign accept      = value_valid & ~pending_full;
  assign boundary    = (state == DRIVE) && (cnt == DWELL_LAST) && (idx == IDX_LAST);
  // Pending and accept are mutually exclusive: a load needs a full buffer, an accept an empty one.
  assign load        = pending_full & (boundary | (state == IDLE));

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    frame_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (cnt == DWELL_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n        = '0;
            frame_done_n = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // A digit is suppressible when it and every more significant nibble are zero.
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) nib[i] = shadow[4*i +: 4];
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run         = run & (nib[i] == 4'h0);
      lz_blank[i] = run;
    end
  end

  assign nib_sel = nib[idx_n];

  hex_decoder u_dec (
    .hex (nib_sel),
    .seg (dec_seg)
  );

  // Outputs are computed from the next state so the registered pins align with state/counter.
  always_comb begin
    sel_n = '1;
    seg_n = 7'h7F;
    if (state_n == DRIVE) begin
      sel_n = ~(NUM_DIGITS'(1) << idx_n);
      if (!(lz_suppress && lz_blank[idx_n])) seg_n = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      digit_sel  <= '1;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      digit_sel  <= sel_n;
      seg        <= seg_n;
      frame_done <= frame_done_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (load) begin
      shadow       <= pending;
      pending_full <= 1'b0;
    end else if (accept) begin
      pending      <= value_in;
      pending_full <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hex_scan_controller.sv
// Randomized scoreboard bench for hex_scan_controller against a frame-position reference model.

module tb_hex_scan_controller;
  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = ND * SLOT;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        enable = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [15:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [3:0]  digit_sel;
  logic [6:0]  seg;
  logic        frame_done;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  hex_scan_controller #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .lz_suppress (lz_suppress),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit_sel   (digit_sel),
    .seg         (seg),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Reference model: scanning is a position within the frame; digit and phase follow by division.
  bit          m_scan = 1'b0;
  bit          m_full = 1'b0;
  bit          was_scan;
  int          m_pos = 0;
  int          d, w;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pend = '0;
  exp_t        e_m;

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_scan = 1'b0; m_full = 1'b0; m_pos = 0; m_shadow = '0; m_pend = '0;
      exp_q.delete();
    end else begin
      was_scan = m_scan;
      if (m_full && (!m_scan || m_pos == FRAME - 1)) begin
        m_shadow = m_pend;
        m_full   = 1'b0;
      end else if (value_valid && !m_full) begin
        m_pend = value_in;
        m_full = 1'b1;
      end
      if (!m_scan) begin
        if (enable) begin m_scan = 1'b1; m_pos = 0; end
      end else if (!enable) begin
        m_scan = 1'b0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      e_m.sel = 4'hF; e_m.seg = 7'h7F; e_m.fd = 1'b0; e_m.rdy = !m_full;
      if (m_scan) begin
        d = m_pos / SLOT;
        w = m_pos % SLOT;
        e_m.fd = was_scan && (m_pos == 0);
        if (w >= BL) begin
          e_m.sel = ~(4'b0001 << d);
          if (!(lz_suppress && d > 0 && (m_shadow >> (4*d)) == 16'h0))
            e_m.seg = hexseg(m_shadow[4*d +: 4]);
        end
      end
      exp_q.push_back(e_m);
    end
  end

  exp_t e_c;
  initial forever begin
    @(negedge clk);
    tests++;
    if (!resetn) begin
      if (digit_sel !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0 || value_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_dark: sel=%b seg=%b fd=%b rdy=%b, want sel=1111 seg=1111111 fd=0 rdy=1",
                 digit_sel, seg, frame_done, value_ready);
      end
    end else if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
    end else begin
      e_c = exp_q.pop_front();
      if (digit_sel !== e_c.sel || seg !== e_c.seg || frame_done !== e_c.fd || value_ready !== e_c.rdy) begin
        fails++;
        $display("FAIL scan_out t=%0t: sel=%b seg=%b fd=%b rdy=%b, want sel=%b seg=%b fd=%b rdy=%b",
                 $time, digit_sel, seg, frame_done, value_ready, e_c.sel, e_c.seg, e_c.fd, e_c.rdy);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic offer(input logic [15:0] v);
    int k;
    k = 0;
    value_in = v;
    value_valid = 1'b1;
    while (!value_ready && k < 200) begin step(1); k++; end
    if (!value_ready) begin
      tests++; fails++;
      $display("FAIL offer_timeout: value_ready=%b after %0d cycles, want 1", value_ready, k);
    end
    step(1);
    value_valid = 1'b0;
  endtask

  task automatic wait_sel(input logic [3:0] target);
    int k;
    k = 0;
    while (digit_sel !== target && k < 200) begin step(1); k++; end
    if (digit_sel !== target) begin
      tests++; fails++;
      $display("FAIL wait_sel_timeout: digit_sel=%b, want %b", digit_sel, target);
    end
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom % 4)
      0: v = v & 16'h00FF;
      1: v = v & 16'h000F;
      2: v = 16'h0000;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    enable = 1'b1;
    step(30);

    step(5);
    offer(16'h12AF);
    step(60);

    offer(16'hBEEF);
    offer(16'h0C0D);
    step(80);

    lz_suppress = 1'b1;
    offer(16'h0050);
    step(60);
    offer(16'h0000);
    step(60);
    lz_suppress = 1'b0;

    wait_sel(4'b1011);
    offer(16'h7777);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(40);

    for (int i = 0; i < 500; i++) begin
      value_valid = ($urandom % 3) == 0;
      value_in    = rand_value();
      if ($urandom % 50 == 0) lz_suppress = ~lz_suppress;
      if (enable && ($urandom % 40 == 0)) enable = 1'b0;
      else if (!enable && ($urandom % 4 == 0)) enable = 1'b1;
      step(1);
    end
    value_valid = 1'b0;
    enable = 1'b1;
    step(40);

    wait_sel(4'b1110);
    offer(16'h9A5C);
    wait_sel(4'b1101);
    #1 resetn = 1'b0;
    #1;
    tests++;
    if (digit_sel !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0 || value_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: sel=%b seg=%b fd=%b rdy=%b, want sel=1111 seg=1111111 fd=0 rdy=1",
               digit_sel, seg, frame_done, value_ready);
    end
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    step(60);

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
